// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between a UART byte stream and a combinational ALU:
// collects operand A, operand B and opcode, captures the result and hands it to the transmitter.
module uart_alu_sequencer #(
  parameter int N_BITS_DATA    = 8,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_empty_i,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  output logic                   rx_rd_o,
  output logic [N_BITS_DATA-1:0] alu_a_o,
  output logic [N_BITS_DATA-1:0] alu_b_o,
  output logic [N_BITS_OP-1:0]   alu_op_o,
  input  logic [N_BITS_DATA-1:0] alu_result_i,
  input  logic                   tx_busy_i,
  input  logic                   tx_done_i,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  output logic                   tx_start_o,
  output logic                   err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W:0]   cnt_inc_s;
  logic             in_get_s;
  logic             cnt_en_s;
  logic             pop_s;
  logic             timeout_s;
  logic             rx_rd_s;
  logic             tx_start_s;
  logic             err_s;
  logic             load_a_s;
  logic             load_b_s;
  logic             load_op_s;
  logic             load_res_s;

  // Pop and timeout decode; a pop is blocked while the previous pop is still visible
  // so the buffer gets one cycle to update rx_empty_i, and a pop always beats a timeout.
  always_comb begin
    in_get_s = 1'b0;
    cnt_en_s = 1'b0;
    case (state_r)
      GET_A: begin
        in_get_s = 1'b1;
        cnt_en_s = 1'b0;
      end
      GET_B, GET_OP: begin
        in_get_s = 1'b1;
        cnt_en_s = 1'b1;
      end
      default: begin
        in_get_s = 1'b0;
        cnt_en_s = 1'b0;
      end
    endcase
    pop_s     = in_get_s && !rx_empty_i && !rx_rd_o;
    cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    timeout_s = cnt_en_s && !pop_s && (cnt_inc_s == CNT_LAST);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= GET_A;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      GET_A: begin
        if (pop_s) state_s = GET_B;
        else       state_s = GET_A;
      end
      GET_B: begin
        if (pop_s)          state_s = GET_OP;
        else if (timeout_s) state_s = GET_A;
        else                state_s = GET_B;
      end
      GET_OP: begin
        if (pop_s)          state_s = EXEC;
        else if (timeout_s) state_s = GET_A;
        else                state_s = GET_OP;
      end
      EXEC: state_s = SEND;
      SEND: begin
        if (!tx_busy_i) state_s = WAIT_TX;
        else            state_s = SEND;
      end
      WAIT_TX: begin
        if (tx_done_i) state_s = GET_A;
        else           state_s = WAIT_TX;
      end
      default: state_s = GET_A;
    endcase
  end

  // Output decode: next values of the pulse registers and capture enables
  always_comb begin
    rx_rd_s    = pop_s;
    err_s      = timeout_s;
    tx_start_s = 1'b0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    load_op_s  = 1'b0;
    load_res_s = 1'b0;
    case (state_r)
      GET_A:   load_a_s   = pop_s;
      GET_B:   load_b_s   = pop_s;
      GET_OP:  load_op_s  = pop_s;
      EXEC:    load_res_s = 1'b1;
      SEND:    tx_start_s = !tx_busy_i;
      WAIT_TX: tx_start_s = 1'b0;
      default: tx_start_s = 1'b0;
    endcase
  end

  // Idle counter: only runs while waiting for B or the opcode, and saturates via the timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pop_s || !cnt_en_s || timeout_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_inc_s[CNT_W-1:0];
    end
  end

  // Registered outputs: pulses are glitch-free and data holds until its next capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_rd_o    <= 1'b0;
      tx_start_o <= 1'b0;
      err_o      <= 1'b0;
      alu_a_o    <= {N_BITS_DATA{1'b0}};
      alu_b_o    <= {N_BITS_DATA{1'b0}};
      alu_op_o   <= {N_BITS_OP{1'b0}};
      tx_data_o  <= {N_BITS_DATA{1'b0}};
    end else begin
      rx_rd_o    <= rx_rd_s;
      tx_start_o <= tx_start_s;
      err_o      <= err_s;
      if (load_a_s)   alu_a_o   <= rx_data_i;
      if (load_b_s)   alu_b_o   <= rx_data_i;
      if (load_op_s)  alu_op_o  <= rx_data_i[N_BITS_OP-1:0];
      if (load_res_s) tx_data_o <= alu_result_i;
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer: a byte-queue receive buffer, a small ALU and
// table-driven frames, plus hand sequences for busy, timeout, mid-frame reset and overrun.
module tb_uart_alu_sequencer;
  localparam int W   = 8;
  localparam int OPW = 6;
  localparam int TO  = 16;

  logic           clock;
  logic           reset;
  logic           rx_empty_i;
  logic [W-1:0]   rx_data_i;
  logic           rx_rd_o;
  logic [W-1:0]   alu_a_o;
  logic [W-1:0]   alu_b_o;
  logic [OPW-1:0] alu_op_o;
  logic [W-1:0]   alu_result_i;
  logic           tx_busy_i;
  logic           tx_done_i;
  logic [W-1:0]   tx_data_o;
  logic           tx_start_o;
  logic           err_o;

  uart_alu_sequencer #(.N_BITS_DATA(W), .N_BITS_OP(OPW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_empty_i(rx_empty_i), .rx_data_i(rx_data_i),
    .rx_rd_o(rx_rd_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .err_o(err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ALU (MIPS-style function codes)
  always_comb begin
    case (alu_op_o)
      6'h20:   alu_result_i = alu_a_o + alu_b_o;
      6'h22:   alu_result_i = alu_a_o - alu_b_o;
      6'h24:   alu_result_i = alu_a_o & alu_b_o;
      6'h25:   alu_result_i = alu_a_o | alu_b_o;
      6'h26:   alu_result_i = alu_a_o ^ alu_b_o;
      6'h27:   alu_result_i = ~(alu_a_o | alu_b_o);
      default: alu_result_i = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] q[$];
  int checks, failures, cyc;
  int n_pop, n_start, n_err, b2b;
  int last_pop_cyc, last_start_cyc, last_err_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_rx();
    if (q.size() == 0) begin
      rx_empty_i = 1'b1;
      rx_data_i  = 8'h00;
    end else begin
      rx_empty_i = 1'b0;
      rx_data_i  = q[0];
    end
  endtask

  // One clock: the buffer drops its head at the edge that ends a cycle with rx_rd_o high
  task automatic step();
    logic rd_prev;
    rd_prev = rx_rd_o;
    @(posedge clock);
    #1;
    cyc++;
    if (rd_prev && q.size() > 0) void'(q.pop_front());
    drive_rx();
    if (rx_rd_o) begin
      n_pop++;
      last_pop_cyc = cyc;
      if (rd_prev) b2b++;
    end
    if (tx_start_o) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (err_o) begin
      n_err++;
      last_err_cyc = cyc;
    end
  endtask

  function automatic int sel(input int which);
    case (which)
      0:       return n_pop;
      1:       return n_start;
      default: return n_err;
    endcase
  endfunction

  task automatic wait_cnt(input string what, input int which, input int target, input int bound);
    int k;
    k = 0;
    while (sel(which) < target && k < bound) begin
      step();
      k++;
    end
    check(what, 32'(sel(which)), 32'(target));
  endtask

  task automatic finish_tx();
    tx_done_i = 1'b1;
    step();
    tx_done_i = 1'b0;
    step();
  endtask

  task automatic push(input logic [7:0] v);
    q.push_back(v);
    drive_rx();
  endtask

  task automatic do_frame(input vec_t v, input int idx);
    n_pop   = 0;
    n_start = 0;
    push(v.a);
    push(v.b);
    push(v.opb);
    wait_cnt($sformatf("v%0d_start_seen", idx), 1, 1, 60);
    check($sformatf("v%0d_latency", idx), 32'(last_start_cyc - last_pop_cyc), 32'd2);
    check($sformatf("v%0d_alu_a", idx), 32'(alu_a_o), 32'(v.a));
    check($sformatf("v%0d_alu_b", idx), 32'(alu_b_o), 32'(v.b));
    check($sformatf("v%0d_alu_op", idx), 32'(alu_op_o), 32'(v.exp_op));
    check($sformatf("v%0d_tx_data", idx), 32'(tx_data_o), 32'(v.exp_res));
    repeat (4) step();
    check($sformatf("v%0d_pops", idx), 32'(n_pop), 32'd3);
    check($sformatf("v%0d_starts", idx), 32'(n_start), 32'd1);
    finish_tx();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    n_pop = 0; n_start = 0; n_err = 0; b2b = 0;
    last_pop_cyc = 0; last_start_cyc = 0; last_err_cyc = 0;
    vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, exp_op: 6'h20, exp_res: 8'h08};
    vecs[1] = '{a: 8'h10, b: 8'h20, opb: 8'hE2, exp_op: 6'h22, exp_res: 8'hF0};
    vecs[2] = '{a: 8'hF0, b: 8'h3C, opb: 8'h24, exp_op: 6'h24, exp_res: 8'h30};
    vecs[3] = '{a: 8'hF0, b: 8'h0F, opb: 8'h65, exp_op: 6'h25, exp_res: 8'hFF};
    vecs[4] = '{a: 8'hAA, b: 8'hFF, opb: 8'h26, exp_op: 6'h26, exp_res: 8'h55};
    vecs[5] = '{a: 8'h00, b: 8'h00, opb: 8'h27, exp_op: 6'h27, exp_res: 8'hFF};
    vecs[6] = '{a: 8'hFF, b: 8'h01, opb: 8'h20, exp_op: 6'h20, exp_res: 8'h00};

    reset = 1'b1; tx_busy_i = 1'b0; tx_done_i = 1'b0;
    drive_rx();
    repeat (3) @(posedge clock);
    #1;
    check("rst_alu_a", 32'(alu_a_o), 32'd0);
    check("rst_alu_b", 32'(alu_b_o), 32'd0);
    check("rst_alu_op", 32'(alu_op_o), 32'd0);
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_pulses", {29'd0, rx_rd_o, tx_start_o, err_o}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) do_frame(vecs[i], i);

    // Transmitter busy on entry to SEND for 50 cycles
    tx_busy_i = 1'b1; n_pop = 0; n_start = 0;
    push(8'h01); push(8'h02); push(8'h20);
    wait_cnt("busy_pops", 0, 3, 20);
    repeat (52) step();
    check("busy_no_start", 32'(n_start), 32'd0);
    tx_busy_i = 1'b0;
    step();
    check("busy_start_pulse", 32'(tx_start_o), 32'd1);
    step();
    check("busy_start_single", 32'(n_start), 32'd1);
    check("busy_tx_data", 32'(tx_data_o), 32'h03);
    finish_tx();

    // Fourth byte arriving while waiting for the transmitter
    n_pop = 0; n_start = 0;
    push(8'h07); push(8'h02); push(8'h20); push(8'h11);
    wait_cnt("ovr_start_seen", 1, 1, 60);
    repeat (5) step();
    check("ovr_pops_held", 32'(n_pop), 32'd3);
    check("ovr_byte_buffered", 32'(q.size()), 32'd1);
    check("ovr_tx_data", 32'(tx_data_o), 32'h09);
    finish_tx();
    wait_cnt("ovr_fourth_pop", 0, 4, 10);
    step();
    check("ovr_next_a", 32'(alu_a_o), 32'h11);
    n_start = 0;
    push(8'h22); push(8'h20);
    wait_cnt("ovr_frame2_start", 1, 1, 60);
    check("ovr_frame2_tx", 32'(tx_data_o), 32'h33);
    finish_tx();

    // Timeout: pop on the last allowed cycle wins, then the opcode never arrives
    n_pop = 0; n_start = 0; n_err = 0;
    push(8'h44);
    wait_cnt("to_a_pop", 0, 1, 10);
    while (cyc < last_pop_cyc + 14) step();
    push(8'h66);
    step();
    check("to_boundary_pop", 32'(rx_rd_o), 32'd1);
    check("to_boundary_no_err", 32'(n_err), 32'd0);
    wait_cnt("to_err_seen", 2, 1, 40);
    check("to_err_cycle", 32'(last_err_cyc - last_pop_cyc), 32'd15);
    step();
    check("to_err_single", 32'(err_o), 32'd0);
    check("to_keep_a", 32'(alu_a_o), 32'h44);
    check("to_keep_b", 32'(alu_b_o), 32'h66);
    check("to_keep_op", 32'(alu_op_o), 32'h20);
    check("to_keep_tx", 32'(tx_data_o), 32'h33);
    check("to_no_start", 32'(n_start), 32'd0);
    push(8'h55);
    wait_cnt("to_next_pop", 0, 3, 10);
    step();
    check("to_next_a", 32'(alu_a_o), 32'h55);
    push(8'h01); push(8'h20);
    wait_cnt("to_frame_start", 1, 1, 60);
    check("to_frame_tx", 32'(tx_data_o), 32'h56);
    finish_tx();

    // Reset between the B and opcode bytes
    n_pop = 0; n_start = 0;
    push(8'h09); push(8'h08);
    wait_cnt("mr_ab_pops", 0, 2, 10);
    step();
    reset = 1'b1;
    q.delete();
    drive_rx();
    #2;
    check("mr_alu_a", 32'(alu_a_o), 32'd0);
    check("mr_alu_b", 32'(alu_b_o), 32'd0);
    check("mr_tx_data", 32'(tx_data_o), 32'd0);
    step();
    reset = 1'b0;
    n_pop = 0;
    push(8'h20);
    wait_cnt("mr_first_pop", 0, 1, 10);
    repeat (10) step();
    check("mr_no_start", 32'(n_start), 32'd0);
    check("mr_byte_is_a", 32'(alu_a_o), 32'h20);
    push(8'h03); push(8'h20);
    wait_cnt("mr_frame_start", 1, 1, 60);
    check("mr_frame_latency", 32'(last_start_cyc - last_pop_cyc), 32'd2);
    check("mr_frame_tx", 32'(tx_data_o), 32'h23);
    finish_tx();

    check("rd_never_back_to_back", 32'(b2b), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 The block SHALL have parameter N_BITS_DATA, default 8, the width of operand, result and UART byte.
REQ-002 The block SHALL have parameter N_BITS_OP, default 6, the opcode width, taken from the low bits of the received opcode byte.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, the idle cycles allowed between bytes of one frame.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset.
REQ-005 The block SHALL have the following ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- rx_empty_i  in  1  low = received byte available on rx_data_i.
- rx_data_i  in  N_BITS_DATA  head byte of the UART receive buffer.
- rx_rd_o  out  1  one-cycle pop of the receive buffer.
- alu_a_o  out  N_BITS_DATA  registered operand A to the ALU.
- alu_b_o  out  N_BITS_DATA  registered operand B to the ALU.
- alu_op_o  out  N_BITS_OP  registered opcode to the ALU.
- alu_result_i  in  N_BITS_DATA  combinational ALU result.
- tx_busy_i  in  1  transmitter busy.
- tx_done_i  in  1  one-cycle pulse at end of the transmitted stop bit.
- tx_data_o  out  N_BITS_DATA  byte to transmit, held from capture until the next frame.
- tx_start_o  out  1  one-cycle transmit request.
- err_o  out  1  one-cycle pulse on frame timeout.

Function
REQ-006 The FSM SHALL have states GET_A, GET_B, GET_OP, EXEC, SEND and WAIT_TX, with GET_A as the reset state.
REQ-007 In each GET_* state, with rx_empty_i=0 and rx_rd_o=0 in the previous cycle, the block SHALL assert rx_rd_o for exactly one cycle.
REQ-008 In that same cycle the block SHALL capture rx_data_i into the target register and advance to the next state.
REQ-009 rx_rd_o SHALL never be high in two consecutive cycles, giving the buffer one cycle to update rx_empty_i.
REQ-010 Capture order SHALL be GET_A->alu_a_o, GET_B->alu_b_o, GET_OP->alu_op_o (rx_data_i[N_BITS_OP-1:0]), then the FSM SHALL go to EXEC.
REQ-011 EXEC SHALL last exactly one cycle, capture alu_result_i into tx_data_o, then go to SEND.
REQ-012 In SEND, if tx_busy_i=0, the block SHALL pulse tx_start_o for one cycle and go to WAIT_TX.
REQ-013 In SEND, if tx_busy_i=1, the block SHALL stay in SEND with tx_start_o=0.
REQ-014 In WAIT_TX, tx_done_i=1 SHALL return the FSM to GET_A.
REQ-015 No rx_rd_o SHALL be issued in EXEC, SEND or WAIT_TX; bytes arriving then remain buffered.
REQ-016 A timeout counter SHALL clear on every pop and in GET_A, EXEC, SEND and WAIT_TX, and SHALL increment each cycle in GET_B and GET_OP.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to GET_A, pulse err_o for one cycle, and leave alu_a_o, alu_b_o, alu_op_o and tx_data_o unchanged.
REQ-018 If a timeout and a pop are possible in the same cycle, the pop SHALL win and no timeout SHALL occur.
REQ-019 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES) and SHALL never wrap.
REQ-020 Latency from the opcode pop to tx_start_o SHALL be 2 cycles when tx_busy_i=0.
REQ-021 No glitches SHALL appear on the output pulses rx_rd_o, tx_start_o and err_o.

Reset
REQ-022 Reset SHALL force the FSM to GET_A and the timeout counter to 0.
REQ-023 Reset SHALL drive alu_a_o, alu_b_o, alu_op_o and tx_data_o to 0.
REQ-024 Reset SHALL drive rx_rd_o, tx_start_o and err_o to 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame, and no tx_start_o SHALL follow release.

Verification
REQ-026 Bytes 0x05, 0x03, 0x20 with alu_result_i=0x08 -> alu_a_o=0x05, alu_b_o=0x03, alu_op_o=0x20, tx_data_o=0x08, one tx_start_o pulse 2 cycles after the 3rd pop.
REQ-027 rx_empty_i held 0 continuously with 3 bytes -> rx_rd_o pulses separated by at least 1 low cycle, exactly 3 pops, then none until tx_done_i.
REQ-028 tx_busy_i=1 on entry to SEND for 50 cycles -> tx_start_o stays 0, then one pulse the cycle tx_busy_i falls.
REQ-029 TIMEOUT_CYCLES=16, A sent then no byte -> err_o pulse at cycle 15 after the pop, FSM in GET_A, next byte lands in alu_a_o.
REQ-030 reset asserted between the B and OP bytes -> all outputs 0, no tx_start_o; a full new frame then completes normally.
REQ-031 A 4th byte arriving during WAIT_TX -> not popped until after tx_done_i, then captured as the next A.
